// File: rtl/fir_out_decim_fifo_pkg.sv
// Shared sample types and saturation helper for the FIR stream path.
// No ports; imported by the FIR wrapper and the output stage.
package fir_stream_pkg;

    localparam int SAMPLE_W = 16;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    localparam sample_t SAMPLE_MAX = 16'sh7FFF;
    localparam sample_t SAMPLE_MIN = 16'sh8000;

    localparam logic signed [18:0] WIDE_MAX = 19'sd32767;
    localparam logic signed [18:0] WIDE_MIN = -19'sd32768;

    // Clamp a 19-bit intermediate into the 16-bit sample range.
    function automatic sample_t sat16(input logic signed [18:0] x);
        sample_t r;
        if (x > WIDE_MAX) begin
            r = SAMPLE_MAX;
        end else if (x < WIDE_MIN) begin
            r = SAMPLE_MIN;
        end else begin
            r = x[15:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/fir_out_decim_fifo_sync_fifo.sv
// First-word-fall-through FIFO; output register counts toward DEPTH.
// Ports: wr_en/wr_data in, rd_valid/rd_ready/rd_data out, count, drop.
module sync_fifo_fwft #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_ready,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] count,
    output logic             drop
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;

    logic             pop;
    logic             full;
    logic             accept;
    logic             mem_empty;
    logic             direct;
    logic             mem_we;
    logic             mem_rd;
    logic [CNT_W-1:0] mem_cnt;

    always_comb begin
        pop       = out_valid_q && rd_ready;
        full      = (count_q == CNT_W'(DEPTH));
        accept    = wr_en && (!full || pop);
        drop      = wr_en && !accept;
        mem_cnt   = count_q - CNT_W'(out_valid_q);
        mem_empty = (mem_cnt == '0);
        // Bypass storage when the output register is (or is becoming) free
        // and nothing older is waiting behind it.
        direct    = accept && (!out_valid_q || (pop && mem_empty));
        mem_we    = accept && !direct;
        mem_rd    = pop && !mem_empty;
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        if (pop) begin
            out_valid_d = 1'b0;
        end
        if (mem_rd) begin
            out_valid_d = 1'b1;
            out_data_d  = mem_q[rd_ptr_q];
            rd_ptr_d    = rd_ptr_q + AW'(1);
        end
        if (direct) begin
            out_valid_d = 1'b1;
            out_data_d  = wr_data;
        end
        if (mem_we) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (accept && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!accept && pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign rd_valid = out_valid_q;
    assign rd_data  = out_data_q;
    assign count    = count_q;

endmodule

// File: rtl/fir_out_decim_fifo.sv
// FIR output stage: decimate, saturating gain, FWFT buffer, AXIS master.
// Ports: s_axis_data_* in (no tready), m_axis_data_* out, fifo_count, overflow.
module fir_out_decim_fifo
    import fir_stream_pkg::*;
#(
    parameter int DECIM = 4,
    parameter int DEPTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             s_axis_data_tvalid,
    input  logic [15:0]      s_axis_data_tdata,
    input  logic [1:0]       gain_shift,
    output logic             m_axis_data_tvalid,
    input  logic             m_axis_data_tready,
    output logic [15:0]      m_axis_data_tdata,
    output logic [CNT_W-1:0] fifo_count,
    output logic             overflow,
    input  logic             clr_overflow
);

    localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;

    logic [PH_W-1:0]   phase_q, phase_d;
    logic              g_valid_q, g_valid_d;
    sample_t           g_data_q, g_data_d;
    logic              overflow_q, overflow_d;

    logic              keep;
    logic signed [18:0] ext;
    logic signed [18:0] prod;
    logic              drop;

    always_comb begin
        keep    = s_axis_data_tvalid && (phase_q == '0);
        phase_d = phase_q;
        if (s_axis_data_tvalid) begin
            if (phase_q == PH_W'(DECIM - 1)) begin
                phase_d = '0;
            end else begin
                phase_d = phase_q + PH_W'(1);
            end
        end
        ext       = {{3{s_axis_data_tdata[15]}}, s_axis_data_tdata};
        prod      = ext <<< gain_shift;
        g_valid_d = keep;
        g_data_d  = keep ? sat16(prod) : g_data_q;
        // A fresh drop beats a simultaneous clear.
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            phase_q    <= '0;
            g_valid_q  <= 1'b0;
            g_data_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            g_valid_q  <= g_valid_d;
            g_data_q   <= g_data_d;
            overflow_q <= overflow_d;
        end
    end

    sync_fifo_fwft #(
        .WIDTH (SAMPLE_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk      (aclk),
        .rst      (areset),
        .wr_en    (g_valid_q),
        .wr_data  (g_data_q),
        .rd_ready (m_axis_data_tready),
        .rd_valid (m_axis_data_tvalid),
        .rd_data  (m_axis_data_tdata),
        .count    (fifo_count),
        .drop     (drop)
    );

    assign overflow = overflow_q;

endmodule

// File: tb/tb_fir_out_decim_fifo.sv
// Self-checking bench: three instances (DECIM 4, 1, 3) on shared stimulus.
// Index 0 = DECIM 4, 1 = DECIM 1, 2 = DECIM 3.
module tb_fir_out_decim_fifo;

    logic             clk = 1'b0;
    logic             areset;
    logic             s_valid;
    logic [15:0]      s_data;
    logic [1:0]       gain;
    logic             ready;
    logic             clr;
    logic [2:0]       v;
    logic [2:0][15:0] d;
    logic [2:0][4:0]  cnt;
    logic [2:0]       ovf;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fir_out_decim_fifo #(.DECIM(4), .DEPTH(16), .CNT_W(5)) u4 (
        .aclk(clk), .areset(areset),
        .s_axis_data_tvalid(s_valid), .s_axis_data_tdata(s_data),
        .gain_shift(gain),
        .m_axis_data_tvalid(v[0]), .m_axis_data_tready(ready),
        .m_axis_data_tdata(d[0]), .fifo_count(cnt[0]),
        .overflow(ovf[0]), .clr_overflow(clr)
    );

    fir_out_decim_fifo #(.DECIM(1), .DEPTH(16), .CNT_W(5)) u1 (
        .aclk(clk), .areset(areset),
        .s_axis_data_tvalid(s_valid), .s_axis_data_tdata(s_data),
        .gain_shift(gain),
        .m_axis_data_tvalid(v[1]), .m_axis_data_tready(ready),
        .m_axis_data_tdata(d[1]), .fifo_count(cnt[1]),
        .overflow(ovf[1]), .clr_overflow(clr)
    );

    fir_out_decim_fifo #(.DECIM(3), .DEPTH(16), .CNT_W(5)) u3 (
        .aclk(clk), .areset(areset),
        .s_axis_data_tvalid(s_valid), .s_axis_data_tdata(s_data),
        .gain_shift(gain),
        .m_axis_data_tvalid(v[2]), .m_axis_data_tready(ready),
        .m_axis_data_tdata(d[2]), .fifo_count(cnt[2]),
        .overflow(ovf[2]), .clr_overflow(clr)
    );

    typedef struct {
        logic signed [15:0] din;
        logic [1:0]         g;
        int                 exp;
    } vec_t;

    vec_t tbl[13];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        areset = 1'b1;
        step();
        step();
        areset = 1'b0;
        step();
    endtask

    // Drain instance k with ready held high, returning the popped samples.
    task automatic drain(input int k, input int cycles, output int q[$]);
        q = {};
        ready = 1'b1;
        s_valid = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            if (v[k]) q.push_back(int'($signed(d[k])));
            step();
        end
        ready = 1'b0;
    endtask

    initial begin
        int got[$];
        int got1[$];
        int expq[$];
        int first;
        int rcv;
        logic pv, pr;
        logic [15:0] pd;

        tbl[0]  = '{16'sd8191,   2'd2, 32764};
        tbl[1]  = '{16'sd8192,   2'd2, 32767};
        tbl[2]  = '{-16'sd8192,  2'd2, -32768};
        tbl[3]  = '{-16'sd8193,  2'd2, -32768};
        tbl[4]  = '{16'sd32767,  2'd2, 32767};
        tbl[5]  = '{-16'sd1,     2'd3, -8};
        tbl[6]  = '{16'sd4096,   2'd3, 32767};
        tbl[7]  = '{16'sd4095,   2'd3, 32760};
        tbl[8]  = '{-16'sd4096,  2'd3, -32768};
        tbl[9]  = '{-16'sd4097,  2'd3, -32768};
        tbl[10] = '{16'sd100,    2'd1, 200};
        tbl[11] = '{-16'sd32768, 2'd0, -32768};
        tbl[12] = '{16'sd12345,  2'd0, 12345};

        areset  = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        gain    = '0;
        ready   = 1'b0;
        clr     = 1'b0;
        do_reset();

        chk("rst_valid", int'(v[1]), 0);
        chk("rst_data", int'(d[1]), 0);
        chk("rst_count", int'(cnt[1]), 0);
        chk("rst_ovf", int'(ovf[1]), 0);

        // Decimation by 4 with first-output latency.
        ready = 1'b1;
        first = -1;
        got = {};
        for (int c = 1; c <= 20; c++) begin
            s_valid = (c <= 12);
            s_data  = 16'(c);
            step();
            if (v[0]) begin
                if (first < 0) first = c;
                got.push_back(int'(d[0]));
            end
        end
        s_valid = 1'b0;
        chk("dec_latency", first, 2);
        chk("dec_n", got.size(), 3);
        for (int i = 0; i < got.size(); i++) chk("dec_val", got[i], 1 + 4 * i);

        // Gain and saturation vectors on the pass-through instance.
        do_reset();
        ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            s_valid = 1'b1;
            s_data  = tbl[i].din;
            gain    = tbl[i].g;
            step();
            s_valid = 1'b0;
            step();
            chk("sat_valid", int'(v[1]), 1);
            chk("sat_data", int'($signed(d[1])), tbl[i].exp);
            step();
        end
        gain = '0;

        // Overflow: 20 beats into a stalled 16-deep buffer.
        do_reset();
        ready = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            s_valid = 1'b1;
            s_data  = 16'(i);
            step();
        end
        s_valid = 1'b0;
        step();
        step();
        chk("ovf_count", int'(cnt[1]), 16);
        chk("ovf_flag", int'(ovf[1]), 1);
        drain(1, 40, got);
        chk("ovf_drain_n", got.size(), 16);
        for (int i = 0; i < got.size(); i++) chk("ovf_drain", got[i], i + 1);
        chk("ovf_count0", int'(cnt[1]), 0);

        // Full buffer with a write landing on a single-cycle pop.
        do_reset();
        ready = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            s_valid = 1'b1;
            s_data  = 16'(i);
            step();
        end
        s_valid = 1'b0;
        step();
        step();
        chk("full_count", int'(cnt[1]), 16);
        chk("full_ovf0", int'(ovf[1]), 0);
        s_valid = 1'b1;
        s_data  = 16'd17;
        step();
        s_valid = 1'b0;
        ready   = 1'b1;
        step();
        ready   = 1'b0;
        step();
        chk("fullpop_count", int'(cnt[1]), 16);
        chk("fullpop_ovf", int'(ovf[1]), 0);
        s_valid = 1'b1;
        s_data  = 16'd18;
        step();
        s_valid = 1'b0;
        clr     = 1'b1;
        step();
        clr     = 1'b0;
        chk("clr_vs_drop", int'(ovf[1]), 1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_alone", int'(ovf[1]), 0);
        drain(1, 40, got);
        chk("full_drain_n", got.size(), 16);
        for (int i = 0; i < got.size(); i++) chk("full_drain", got[i], i + 2);

        // Asynchronous reset with samples buffered.
        do_reset();
        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1;
            s_data  = 16'(50 + i);
            step();
        end
        s_valid = 1'b0;
        step();
        step();
        chk("pre_rst_count", int'(cnt[1]), 5);
        #3;
        areset = 1'b1;
        #1;
        chk("arst_valid", int'(v[1]), 0);
        chk("arst_data", int'(d[1]), 0);
        chk("arst_count", int'(cnt[1]), 0);
        step();
        step();
        areset = 1'b0;
        step();
        ready = 1'b1;
        got = {};
        got1 = {};
        for (int c = 0; c < 10; c++) begin
            s_valid = (c < 4);
            s_data  = 16'(100 + c);
            step();
            if (v[0]) got.push_back(int'(d[0]));
            if (v[1]) got1.push_back(int'(d[1]));
        end
        s_valid = 1'b0;
        chk("arst_d4_n", got.size(), 1);
        if (got.size() > 0) chk("arst_d4_first", got[0], 100);
        chk("arst_d1_n", got1.size(), 4);
        if (got1.size() > 0) chk("arst_d1_first", got1[0], 100);

        // Random backpressure over a ramp, DECIM 3.
        do_reset();
        expq = {};
        rcv  = 0;
        pv   = 1'b0;
        pr   = 1'b1;
        pd   = '0;
        for (int i = 0; i < 1200; i++) begin
            if (pv && !pr) begin
                chk("hold_valid", int'(v[2]), 1);
                chk("hold_data", int'(d[2]), int'(pd));
            end
            ready   = 1'($urandom_range(0, 1));
            s_valid = 1'b1;
            s_data  = 16'(i);
            if (i % 3 == 0) expq.push_back(i);
            if (v[2] && ready) begin
                rcv++;
                chk("rand_data", int'(d[2]),
                    (expq.size() > 0) ? expq.pop_front() : -1);
            end
            pv = v[2];
            pr = ready;
            pd = d[2];
            step();
        end
        s_valid = 1'b0;
        ready   = 1'b1;
        for (int c = 0; c < 60; c++) begin
            if (v[2]) begin
                rcv++;
                chk("rand_tail", int'(d[2]),
                    (expq.size() > 0) ? expq.pop_front() : -1);
            end
            step();
        end
        ready = 1'b0;
        chk("rand_rcv", rcv, 400);
        chk("rand_left", expq.size(), 0);
        chk("rand_ovf", int'(ovf[2]), 0);
        chk("rand_count", int'(cnt[2]), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
